// File: rtl/dm_hart_status.sv
// dm_hart_status
//   Per-hart run-control status tracker for the debug module. It keeps the
//   sticky havereset and resumeack bits for each hart. It runs the
//   resume-request handshake toward the harts. It also registers the DMSTATUS
//   view of the hart selected by hartsel_i.
//
// Ports
//   clk_i           sole clock, rising edge
//   rst_i           synchronous active-high reset
//   dmactive_i      DMCONTROL.dmactive; 0 clears all state like rst_i
//   hartsel_i       selected hart index (HSELW bits)
//   resumereq_i     one-cycle resume request pulse for hartsel_i
//   ackhavereset_i  one-cycle havereset acknowledge pulse for hartsel_i
//   hart_halted_i   per-hart halted level
//   hart_running_i  per-hart running level
//   hart_unavail_i  per-hart unavailable level
//   hart_reset_i    per-hart "was reset" level or pulse
//   resume_req_o    per-hart resume request, held until the hart runs
//   dmstatus_o      registered DMSTATUS word
//
// Per-hart FSM
//   state    | meaning
//   IDLE     | no resume outstanding
//   RESUMING | resume_req_o asserted, waiting for the hart to report running
module dm_hart_status #(
  parameter int NHARTS          = 4,
  parameter int HSELW           = 4,
  parameter bit IMPEBREAK       = 1'b0,
  parameter bit HASRESETHALTREQ = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dmactive_i,
  input  logic [HSELW-1:0]  hartsel_i,
  input  logic              resumereq_i,
  input  logic              ackhavereset_i,
  input  logic [NHARTS-1:0] hart_halted_i,
  input  logic [NHARTS-1:0] hart_running_i,
  input  logic [NHARTS-1:0] hart_unavail_i,
  input  logic [NHARTS-1:0] hart_reset_i,
  output logic [NHARTS-1:0] resume_req_o,
  output logic [31:0]       dmstatus_o
);

  typedef enum logic {IDLE, RESUMING} state_t;

  localparam logic [31:0] STATUS_RST = {9'b0, IMPEBREAK, 14'b0, 1'b1, 1'b0,
                                        HASRESETHALTREQ, 1'b0, 4'd3};

  state_t            state_q [NHARTS];
  state_t            state_d [NHARTS];
  logic [NHARTS-1:0] havereset_q, havereset_d;
  logic [NHARTS-1:0] resumeack_q, resumeack_d;
  logic [NHARTS-1:0] sel_hit;
  logic [NHARTS-1:0] eff_halted, eff_running;
  logic              clear;
  logic              nonexist;
  logic              sel_hr, sel_ra, sel_un, sel_run, sel_hal;
  logic [31:0]       status_d;

  assign clear = rst_i | ~dmactive_i;

  // sel_hit is one-hot for an implemented hart and all-zero otherwise, so an
  // out-of-range hartsel_i can never reach per-hart state.
  always_comb begin
    sel_hit = '0;
    for (int h = 0; h < NHARTS; h++) begin
      sel_hit[h] = (hartsel_i == HSELW'(h));
    end
  end

  assign nonexist    = (hartsel_i >= HSELW'(NHARTS));
  assign eff_halted  = hart_halted_i & ~hart_unavail_i;
  assign eff_running = hart_running_i & ~hart_halted_i & ~hart_unavail_i;

  always_comb begin
    havereset_d = havereset_q;
    resumeack_d = resumeack_q;
    for (int h = 0; h < NHARTS; h++) begin
      state_d[h] = state_q[h];
      case (state_q[h])
        IDLE: begin
          if (resumereq_i && sel_hit[h] && eff_halted[h]) begin
            state_d[h]     = RESUMING;
            resumeack_d[h] = 1'b0;
          end
        end
        RESUMING: begin
          if (eff_running[h]) begin
            state_d[h]     = IDLE;
            resumeack_d[h] = 1'b1;
          end
        end
        default: state_d[h] = IDLE;
      endcase
      // A new reset report takes priority over a same-cycle acknowledge.
      if (hart_reset_i[h]) begin
        havereset_d[h] = 1'b1;
      end else if (ackhavereset_i && sel_hit[h]) begin
        havereset_d[h] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      for (int h = 0; h < NHARTS; h++) begin
        state_q[h] <= IDLE;
      end
      havereset_q <= '0;
      resumeack_q <= '0;
    end else begin
      for (int h = 0; h < NHARTS; h++) begin
        state_q[h] <= state_d[h];
      end
      havereset_q <= havereset_d;
      resumeack_q <= resumeack_d;
    end
  end

  always_comb begin
    resume_req_o = '0;
    for (int h = 0; h < NHARTS; h++) begin
      resume_req_o[h] = (state_q[h] == RESUMING);
    end
  end

  // Only one hart is ever selected, so each any* bit mirrors its all* bit.
  assign sel_hr  = |(havereset_q & sel_hit);
  assign sel_ra  = |(resumeack_q & sel_hit);
  assign sel_un  = |(hart_unavail_i & sel_hit);
  assign sel_run = |(eff_running & sel_hit);
  assign sel_hal = |(eff_halted & sel_hit);

  assign status_d = {9'b0, IMPEBREAK, 2'b0,
                     {2{sel_hr}}, {2{sel_ra}}, {2{nonexist}},
                     {2{sel_un}}, {2{sel_run}}, {2{sel_hal}},
                     1'b1, 1'b0, HASRESETHALTREQ, 1'b0, 4'd3};

  always_ff @(posedge clk_i) begin
    if (clear) begin
      dmstatus_o <= STATUS_RST;
    end else begin
      dmstatus_o <= status_d;
    end
  end

endmodule

// File: tb/tb_dm_hart_status.sv
module tb_dm_hart_status;

  logic        clk = 1'b0;
  logic        rst, dmactive;
  logic [3:0]  hartsel;
  logic        resumereq, ackhavereset;
  logic [3:0]  hart_halted, hart_running, hart_unavail, hart_reset;
  logic [3:0]  resume_req;
  logic [31:0] dmstatus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_hart_status #(.NHARTS(4), .HSELW(4), .IMPEBREAK(1'b0), .HASRESETHALTREQ(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive), .hartsel_i(hartsel),
    .resumereq_i(resumereq), .ackhavereset_i(ackhavereset),
    .hart_halted_i(hart_halted), .hart_running_i(hart_running),
    .hart_unavail_i(hart_unavail), .hart_reset_i(hart_reset),
    .resume_req_o(resume_req), .dmstatus_o(dmstatus)
  );

  // One cycle of inputs and the outputs expected just after the edge that ends it.
  typedef struct {
    logic       rst, dma;
    logic [3:0] sel;
    logic       rq, ack;
    logic [3:0] hal, run, una, hrs;
    logic [3:0] req;
    logic [31:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; dmactive = v.dma; hartsel = v.sel;
    resumereq = v.rq; ackhavereset = v.ack;
    hart_halted = v.hal; hart_running = v.run;
    hart_unavail = v.una; hart_reset = v.hrs;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    drive(v);
    @(posedge clk); #1;
    chk({nm, "_req"}, 32'(resume_req), 32'(v.req));
    chk({nm, "_st"}, dmstatus, v.st);
  endtask

  function automatic vec_t mk(input logic r, input logic d, input logic [3:0] s,
                              input logic q, input logic a, input logic [3:0] hl,
                              input logic [3:0] rn, input logic [3:0] un,
                              input logic [3:0] hr, input logic [3:0] rr,
                              input logic [31:0] st);
    vec_t v;
    v.rst = r; v.dma = d; v.sel = s; v.rq = q; v.ack = a;
    v.hal = hl; v.run = rn; v.una = un; v.hrs = hr; v.req = rr; v.st = st;
    return v;
  endfunction

  // Reference model: per-hart flags, updated from the behavioural rules.
  bit m_res[4], m_hr[4], m_ra[4];

  function automatic logic [31:0] model_status();
    int s;
    bit un, hl, rn;
    logic [31:0] r;
    s = int'(hartsel);
    r = 32'h83;
    if (rst || !dmactive) return 32'h83;
    if (s >= 4) return r + 32'hC000;
    un = hart_unavail[s];
    hl = hart_halted[s] && !un;
    rn = hart_running[s] && !hart_halted[s] && !un;
    if (m_hr[s]) r = r + 32'hC0000;
    if (m_ra[s]) r = r + 32'h30000;
    if (un)      r = r + 32'h3000;
    if (rn)      r = r + 32'hC00;
    if (hl)      r = r + 32'h300;
    return r;
  endfunction

  task automatic model_update();
    bit un, hl, rn;
    for (int h = 0; h < 4; h++) begin
      if (rst || !dmactive) begin
        m_res[h] = 0; m_hr[h] = 0; m_ra[h] = 0;
      end else begin
        un = hart_unavail[h];
        hl = hart_halted[h] && !un;
        rn = hart_running[h] && !hart_halted[h] && !un;
        if (!m_res[h] && resumereq && int'(hartsel) == h && hl) begin
          m_res[h] = 1; m_ra[h] = 0;
        end else if (m_res[h] && rn) begin
          m_res[h] = 0; m_ra[h] = 1;
        end
        if (hart_reset[h]) m_hr[h] = 1;
        else if (ackhavereset && int'(hartsel) == h) m_hr[h] = 0;
      end
    end
  endtask

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    r = '0;
    for (int h = 0; h < 4; h++) r[h] = m_res[h];
    return r;
  endfunction

  initial begin
    logic [31:0] exp_st;

    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h83));

    //            rst dma sel rq ack hal     run     una     hrs     req     status
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000083));
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000083));
    tbl.push_back(mk(0, 1, 5, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000C083));
    tbl.push_back(mk(0, 1, 5, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0000C083));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000383));
    tbl.push_back(mk(0, 1, 1, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 32'h00000383));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 32'h00000C83));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 32'h00030C83));
    tbl.push_back(mk(0, 1, 2, 0, 1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 32'h00000083));
    tbl.push_back(mk(0, 1, 2, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h000C0083));
    tbl.push_back(mk(0, 1, 2, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h000C0083));
    tbl.push_back(mk(0, 1, 2, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000083));
    tbl.push_back(mk(0, 1, 3, 1, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 32'h00000C83));
    tbl.push_back(mk(0, 1, 3, 0, 0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 32'h00000C83));
    tbl.push_back(mk(0, 1, 0, 1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 32'h00000383));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000083));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 32'h00000C83));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 32'h00000C83));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00003083));
    tbl.push_back(mk(0, 1, 0, 1, 0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00003083));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00003083));

    for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // hartsel moves away mid-resume, then rst_i aborts a second resume
    run_vec("seq_rst",   mk(1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000083));
    run_vec("seq_req",   mk(0, 1, 1, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 32'h00000383));
    run_vec("seq_move",  mk(0, 1, 2, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 32'h00000083));
    run_vec("seq_run",   mk(0, 1, 2, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 32'h00000083));
    run_vec("seq_back",  mk(0, 1, 1, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 32'h00030C83));
    run_vec("seq_req2",  mk(0, 1, 1, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 32'h00030383));
    run_vec("seq_abort", mk(1, 1, 1, 0, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000083));
    run_vec("seq_after", mk(0, 1, 1, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 32'h00000C83));
    run_vec("seq_noack", mk(0, 1, 1, 0, 0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 32'h00000C83));

    // randomized traffic against the reference model, starting from reset
    for (int n = 0; n < 3000; n++) begin
      rst          = (n == 0) || ($urandom_range(0, 199) == 0);
      dmactive     = ($urandom_range(0, 99) != 0);
      hartsel      = 4'($urandom_range(0, 7));
      resumereq    = ($urandom_range(0, 2) == 0);
      ackhavereset = ($urandom_range(0, 3) == 0);
      hart_halted  = 4'($urandom);
      hart_running = 4'($urandom);
      hart_unavail = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      hart_reset   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      exp_st = model_status();
      model_update();
      @(posedge clk); #1;
      chk("rnd_req", 32'(resume_req), 32'(model_req()));
      chk("rnd_st", dmstatus, exp_st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
